// File: rtl/redun_mont_carry_resolve_pkg.sv
// Shared types and constants for the redundant-form Montgomery datapath.
// Also holds the carry-resolve stage's per-cycle word count and FSM state type.
package redun_mont_carry_resolve_pkg;

  localparam int WRD_BITS = 16;
  localparam int NUM_WRDS = 65;
  localparam int DAT_BITS = WRD_BITS * NUM_WRDS;

  typedef logic [DAT_BITS-1:0]               fe_t;
  typedef logic [NUM_WRDS-1:0][WRD_BITS:0]   redun0_t;

  // Modulus: top bit set so that 2P exceeds 2^DAT_BITS, odd low part.
  localparam fe_t P = {1'b1, 911'd0, 128'hB7E1_5162_8AED_2A6A_BF71_5880_9CF4_F3C7};

  localparam int CARRY_RESOLVE_WRDS_PER_CYC = 5;
  localparam int CARRY_RESOLVE_NUM_CYC      = NUM_WRDS / CARRY_RESOLVE_WRDS_PER_CYC;
  localparam int CARRY_RESOLVE_IDX_BITS     = $clog2(CARRY_RESOLVE_NUM_CYC);

  typedef logic [1:0] carry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } cr_state_e;

endpackage

// File: rtl/redun_mont_carry_resolve_slice.sv
// One pass of the serial carry/borrow chain: resolves a group of redundant
// words and subtracts the matching modulus words in the same ripple.
module redun_carry_slice
  import redun_mont_carry_resolve_pkg::*;
#(
  parameter int WRDS = CARRY_RESOLVE_WRDS_PER_CYC
) (
  input  logic [WRDS-1:0][WRD_BITS:0]   wrd_i,
  input  logic [WRDS-1:0][WRD_BITS-1:0] p_wrd_i,
  input  carry_t                        carry_i,
  input  logic                          borrow_i,
  output logic [WRDS-1:0][WRD_BITS-1:0] sum_o,
  output logic [WRDS-1:0][WRD_BITS-1:0] diff_o,
  output carry_t                        carry_o,
  output logic                          borrow_o
);

  // Diff of each word uses the already-resolved sum word, so both chains advance together.
  always_comb begin
    logic [WRD_BITS+1:0] s;
    logic [WRD_BITS:0]   d;
    carry_t              c;
    logic                b;
    s      = '0;
    d      = '0;
    c      = carry_i;
    b      = borrow_i;
    sum_o  = '0;
    diff_o = '0;
    for (int i = 0; i < WRDS; i++) begin
      s         = {1'b0, wrd_i[i]} + {{WRD_BITS{1'b0}}, c};
      sum_o[i]  = s[WRD_BITS-1:0];
      c         = s[WRD_BITS+1:WRD_BITS];
      d         = {1'b0, s[WRD_BITS-1:0]} - {1'b0, p_wrd_i[i]} - {{WRD_BITS{1'b0}}, b};
      diff_o[i] = d[WRD_BITS-1:0];
      b         = d[WRD_BITS];
    end
    carry_o  = c;
    borrow_o = b;
  end

endmodule

// File: rtl/redun_mont_carry_resolve.sv
// Carry-resolve stage: turns a redundant result into a canonical residue,
// a few words per cycle, with a single conditional subtraction of P.
module redun_mont_carry_resolve
  import redun_mont_carry_resolve_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  redun0_t i_dat,
  input  logic    i_val,
  output logic    o_rdy,
  output fe_t     o_dat,
  output logic    o_ovf,
  output logic    o_sub,
  output logic    o_val,
  input  logic    i_rdy
);

  localparam int WPC = CARRY_RESOLVE_WRDS_PER_CYC;
  localparam int NC  = CARRY_RESOLVE_NUM_CYC;
  localparam int IW  = CARRY_RESOLVE_IDX_BITS;
  localparam int BW  = $clog2(NUM_WRDS);

  typedef logic [NUM_WRDS-1:0][WRD_BITS-1:0] wrds_t;
  localparam wrds_t P_WRDS = P;

  cr_state_e state_q, state_d;

  logic [IW-1:0] idx_q;
  carry_t        carry_q;
  logic          borrow_q;
  redun0_t       dat_q;
  wrds_t         sum_q, diff_q, sum_d, diff_d;
  fe_t           res_q;
  logic          ovf_q, sub_q;

  logic [BW-1:0]                  wbase;
  logic [WPC-1:0][WRD_BITS-1:0]   slc_sum, slc_diff;
  carry_t                         slc_carry;
  logic                           slc_borrow;
  logic                           accept, last;

  assign wbase  = BW'(idx_q) * BW'(WPC);
  assign accept = (state_q == ST_IDLE) && i_val;
  assign last   = (idx_q == IW'(NC - 1));

  redun_carry_slice #(.WRDS(WPC)) u_slice (
    .wrd_i    (dat_q[wbase +: WPC]),
    .p_wrd_i  (P_WRDS[wbase +: WPC]),
    .carry_i  (carry_q),
    .borrow_i (borrow_q),
    .sum_o    (slc_sum),
    .diff_o   (slc_diff),
    .carry_o  (slc_carry),
    .borrow_o (slc_borrow)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_rdy   = 1'b0;
    o_val   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_rdy = 1'b1;
        if (i_val) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_val = 1'b1;
        if (i_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sum_d                  = sum_q;
    diff_d                 = diff_q;
    sum_d[wbase +: WPC]    = slc_sum;
    diff_d[wbase +: WPC]   = slc_diff;
  end

  // Published result registers only change on the final pass, so they hold through IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dat_q    <= '0;
      idx_q    <= '0;
      carry_q  <= '0;
      borrow_q <= 1'b0;
      sum_q    <= '0;
      diff_q   <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      sub_q    <= 1'b0;
    end else if (accept) begin
      dat_q    <= i_dat;
      idx_q    <= '0;
      carry_q  <= '0;
      borrow_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      carry_q  <= slc_carry;
      borrow_q <= slc_borrow;
      sum_q    <= sum_d;
      diff_q   <= diff_d;
      idx_q    <= idx_q + 1'b1;
      if (last) begin
        res_q <= slc_borrow ? fe_t'(sum_d) : fe_t'(diff_d);
        ovf_q <= |slc_carry;
        sub_q <= ~slc_borrow;
      end
    end
  end

  assign o_dat = res_q;
  assign o_ovf = ovf_q;
  assign o_sub = sub_q;

endmodule
